// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// The nibble width, the FSM state encoding and the counter-width helper live here.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The nibble counter needs at least one bit, even when there is a single nibble.
    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit add cell with carry in and carry out.
// A single instance is reused once per clock by the serial adder.
module nibble_add4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, ci};
    assign s     = total[NIB_W-1:0];
    assign co    = total[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that adds one nibble per clock, with valid/ready handshakes on both sides.
// Defining NIBBLE_SERIAL_ADDER_OVF_EN adds a signed overflow output named ovf.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = cnt_width(NIB);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] nib_cnt;
    logic [NIB_W-1:0] s4;
    logic             c4;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    nibble_add4 u_add4 (
        .a  (opa[NIB_W-1:0]),
        .b  (opb[NIB_W-1:0]),
        .ci (carry),
        .s  (s4),
        .co (c4)
    );

    // Each new nibble result enters at the top, so after NIB shifts nibble 0 sits at the bottom.
    generate
        if (WIDTH == NIB_W) begin : g_single_nibble
            assign sum_next = s4;
        end else begin : g_multi_nibble
            assign sum_next = {s4, sum_reg[WIDTH-1:NIB_W]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            opa     <= '0;
            opb     <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            nib_cnt <= '0;
            cout    <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa     <= a;
                        opb     <= b;
                        carry   <= cin;
                        nib_cnt <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        a_msb   <= a[WIDTH-1];
                        b_msb   <= b[WIDTH-1];
`endif
                        state   <= RUN;
                    end
                end
                RUN: begin
                    opa     <= opa >> NIB_W;
                    opb     <= opb >> NIB_W;
                    sum_reg <= sum_next;
                    carry   <= c4;
                    // Hold the counter on the last nibble so it never wraps.
                    if (nib_cnt == LAST_NIB) begin
                        cout  <= c4;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        ovf   <= (a_msb == b_msb) && (s4[NIB_W-1] != a_msb);
`endif
                        state <= DONE;
                    end else begin
                        nib_cnt <= nib_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that splits both operands into 4-bit nibbles and processes one nibble per clock through a single 4-bit add cell. A registered carry links each nibble to the next. It sits between an operand producer and a result consumer, using valid/ready handshakes on both sides. It trades latency for area when a full-width adder is too large.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4.
- NIB, WIDTH/4, derived local constant; nibbles per operation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  producer presents a, b, cin.
- in_ready  out  1  block can accept an operation; equals (state == IDLE).
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cin  in  1  carry-in to nibble 0.
- out_valid  out  1  result available; equals (state == DONE).
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  registered result, A+B+cin mod 2^WIDTH.
- cout  out  1  registered carry out of bit WIDTH-1.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch a→opa, b→opb, cin→carry, clear nib_cnt, go to RUN.
- RUN, every cycle:
  - {c4,s4} = opa[3:0] + opb[3:0] + carry, 5-bit result.
  - Shift opa and opb right by 4.
  - Shift sum_reg right by 4, inserting s4 at bits [WIDTH-1:WIDTH-4].
  - carry ← c4; nib_cnt++.
  - When nib_cnt == NIB-1, this is the last nibble: also cout ← c4, then go to DONE.
- DONE:
  - out_valid=1; sum and cout hold stable.
  - On out_ready, go to IDLE.
- Inputs outside the handshake are ignored:
  - in_valid is ignored in RUN and DONE; a, b, cin may change freely there.
  - out_ready is ignored outside DONE.
- nib_cnt is $clog2(NIB) bits wide, with a minimum of 1. It never wraps: the RUN→DONE exit occurs at NIB-1.
- WIDTH=4 case: RUN lasts exactly one cycle.
- sum is driven directly from sum_reg. Its contents are meaningful only while out_valid=1.

## Timing
- Reset values:
  - state=IDLE, so in_ready=1 and out_valid=0.
  - sum=0, cout=0, carry=0, nib_cnt=0.
  - Optional ovf=0.
- Reset asserted mid-RUN or in DONE:
  - Immediate return to IDLE; the partial result is discarded.
  - No out_valid pulse occurs for the aborted operation.
- Accept edge = T0. RUN occupies edges T1..TNIB. out_valid rises after edge TNIB, i.e. NIB cycles after acceptance.
- The DONE→IDLE edge is the edge where out_valid & out_ready are both high. in_ready rises in the following cycle.
- Minimum issue interval: NIB+2 cycles (IDLE, NIB×RUN, DONE). For WIDTH=16, one operation every 6 cycles.
- There is no combinational path from any input to any output.

## Configuration
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (out, 1 bit), the signed two's-complement overflow flag.
  - At accept, latch a[WIDTH-1] and b[WIDTH-1].
  - On the last RUN cycle: ovf ← (a_msb == b_msb) && (s4[3] != a_msb).
  - ovf is valid with out_valid and resets to 0.
- Undefined: the ovf port and its registers do not exist. All other behaviour is identical.

## Structure
- Package nibble_serial_adder_pkg holds:
  - NIB_W = 4.
  - State enum state_t {IDLE, RUN, DONE}.
- Sub-module nibble_add4: purely combinational, inputs a[3:0], b[3:0], ci; outputs s[3:0], co. Instantiated once.
- Top-level contents: FSM, operand shift registers, carry register, nib_cnt, sum_reg, and optional ovf logic.

## Test plan
All scenarios use WIDTH=16.
- a=0x1234, b=0x1111, cin=0 → sum=0x2345, cout=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. Checks that the carry propagates through all 4 nibble iterations.
- a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1. Then, with in_valid held high, the next operation is accepted exactly 6 cycles after the first.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b.
  - Required: sum and cout stable, in_ready=0, nothing accepted.
  - Raising out_ready returns the block to IDLE on the next edge.
- Reset in the cycle after the 2nd RUN edge (mid-RUN) of a=0x00FF, b=0x0001.
  - Required: out_valid=0, sum=0, in_ready=1 immediately.
  - A following op a=0x0002, b=0x0003 gives sum=0x0005.
- With NIBBLE_SERIAL_ADDER_OVF_EN defined:
  - a=0x7FFF, b=0x0001 → ovf=1, sum=0x8000.
  - a=0x8000, b=0xFFFF → ovf=1, sum=0x7FFF, cout=1.
  - a=0x1234, b=0x1111 → ovf=0.
